zero_run_detector: RTL

Parametrised, registered successor to the team's combinational 8-bit zero detector. Samples a WIDTH-bit word on each valid cycle. Flags masked-zero words, tracks the length of the current consecutive-zero run, and raises a one-shot event when the run reaches a programmable threshold. It also keeps a saturating total of zero words, and sits on sample streams feeding idle/dead-channel monitoring.

---
 rtl/zero_run_detector.sv | 112 +++++++++++
 1 files changed

// File: rtl/zero_run_detector.sv
// Registered zero-run detector: flags masked-zero samples, tracks the current
// zero run and total zero count, and pulses run_hit when a run reaches threshold.
module zero_run_detector #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] mask,
    input  logic [CNT_W-1:0] threshold,
    output logic             out_valid,
    output logic             is_zero,
    output logic [CNT_W-1:0] run_len,
    output logic             run_hit,
    output logic             run_active,
    output logic [CNT_W-1:0] zero_total
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HIT   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             is_zero_q, is_zero_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic             run_hit_q, run_hit_d;
    logic             run_active_q, run_active_d;
    logic [CNT_W-1:0] zero_total_q, zero_total_d;

    logic             sample_zero;
    logic [CNT_W-1:0] len_inc;
    logic [CNT_W-1:0] total_inc;
    logic [CNT_W-1:0] len_new;
    logic             hit_new;

    assign sample_zero = ((num & mask) == '0);
    assign len_inc     = (run_len_q == CNT_MAX) ? run_len_q : run_len_q + CNT_W'(1);
    assign total_inc   = (zero_total_q == CNT_MAX) ? zero_total_q : zero_total_q + CNT_W'(1);
    assign len_new     = sample_zero ? len_inc : '0;
    // HIT is re-evaluated against the live threshold on every accepted sample
    assign hit_new     = (threshold != '0) && (len_new >= threshold);

    always_comb begin
        state_d      = state_q;
        out_valid_d  = 1'b0;
        is_zero_d    = is_zero_q;
        run_len_d    = run_len_q;
        run_hit_d    = 1'b0;
        run_active_d = run_active_q;
        zero_total_d = zero_total_q;

        if (clear) begin
            state_d      = IDLE;
            is_zero_d    = 1'b0;
            run_len_d    = '0;
            run_active_d = 1'b0;
            zero_total_d = '0;
        end else if (in_valid) begin
            out_valid_d  = 1'b1;
            is_zero_d    = sample_zero;
            run_len_d    = len_new;
            run_active_d = hit_new;
            if (sample_zero) begin
                zero_total_d = total_inc;
            end
            if (len_new == '0) begin
                state_d = IDLE;
            end else if (hit_new) begin
                state_d = HIT;
            end else begin
                state_d = COUNT;
            end
            run_hit_d = hit_new && (state_q != HIT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            is_zero_q    <= 1'b0;
            run_len_q    <= '0;
            run_hit_q    <= 1'b0;
            run_active_q <= 1'b0;
            zero_total_q <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            is_zero_q    <= is_zero_d;
            run_len_q    <= run_len_d;
            run_hit_q    <= run_hit_d;
            run_active_q <= run_active_d;
            zero_total_q <= zero_total_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign is_zero    = is_zero_q;
    assign run_len    = run_len_q;
    assign run_hit    = run_hit_q;
    assign run_active = run_active_q;
    assign zero_total = zero_total_q;

endmodule
